// File: rtl/proc_pkg.sv
// Shared definitions for the processor run/done instruction interface.
// Holds the opcode encodings carried in din[8:6], the instruction issuer
// state encoding and the error codes reported on err_code.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
    localparam logic [1:0] ERR_MVI_TRUNC = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_IMM,
        ST_HALT,
        ST_ERR
    } issuer_state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM for the instruction issuer: DEPTH words of 9 bits.
// Ports:
//   clk          - rising-edge clock
//   we/waddr/wdata - synchronous write port
//   re/raddr     - synchronous read request
//   rdata        - read data, registered; holds its value while re is low
// Neither the array nor the read register is reset.
module prog_ram #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [8:0]               wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [8:0]               rdata
);

    logic [8:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: initiator side of the processor run/done interface.
// Walks a loaded program, drives each word on din with a one-cycle run
// pulse and waits for done; MVI words are followed by their immediate.
// Ports:
//   clk, resetn                     - clock, async active-low reset
//   load_en/load_addr/load_data     - program RAM write (ignored while busy)
//   start, prog_len                 - begin at pc=0 with the given length
//   done                            - processor instruction complete
//   run, din                        - issue pulse and instruction/immediate
//   busy, halted, error, err_code   - status
//   pc                              - current word index
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start
// FETCH    | RAM read of word[pc] in flight
// ISSUE    | instruction on din, run pulsed (unless it is rejected)
// WAIT     | waiting for done on a single-word instruction
// IMM      | immediate on din, waiting for done on an MVI
// HALT     | program completed, sticky until start
// ERR      | aborted, err_code valid, sticky until start
module instr_issuer
    import proc_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [8:0]               load_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     done,
    output logic                     run,
    output logic [8:0]               din,
    output logic                     busy,
    output logic                     halted,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH):0]   pc
);

    localparam int         AW         = $clog2(DEPTH);
    localparam int         PW         = AW + 1;
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);

    issuer_state_t state_q, state_d;
    logic [PW-1:0] pc_d;
    logic [PW-1:0] len_q, len_d;
    logic [7:0]    timer_q, timer_d;
    logic [1:0]    err_d;

    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [8:0]    ram_rdata;

    logic [8:0]    instr;
    logic [2:0]    opcode;
    logic [PW-1:0] pc_inc1;
    logic [PW-1:0] pc_inc2;
    logic [7:0]    timer_inc;

    // The RAM read register doubles as the instruction register: it is only
    // re-read in FETCH and in the ISSUE of an MVI, so it holds the
    // instruction through WAIT and the immediate through IMM.
    assign instr     = ram_rdata;
    assign opcode    = instr[8:6];
    assign pc_inc1   = pc + PW'(1);
    assign pc_inc2   = pc + PW'(2);
    assign timer_inc = timer_q + 8'd1;
    assign ram_we    = load_en & ~busy;

    prog_ram #(
        .DEPTH (DEPTH)
    ) u_prog_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            pc       <= '0;
            len_q    <= '0;
            timer_q  <= '0;
            err_code <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            len_q    <= len_d;
            timer_q  <= timer_d;
            err_code <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        len_d     = len_q;
        timer_d   = timer_q;
        err_d     = err_code;
        run       = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = pc[AW-1:0];

        case (state_q)
            ST_IDLE, ST_HALT, ST_ERR: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    err_d   = ERR_NONE;
                    timer_d = '0;
                    state_d = (prog_len == '0) ? ST_HALT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                ram_re  = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                timer_d = '0;
                if (!op_is_legal(opcode)) begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_ERR;
                end else if (opcode == OP_MVI) begin
                    // An MVI needs its immediate inside the program.
                    if (pc_inc1 >= len_q) begin
                        err_d   = ERR_MVI_TRUNC;
                        state_d = ST_ERR;
                    end else begin
                        run       = 1'b1;
                        ram_re    = 1'b1;
                        ram_raddr = pc_inc1[AW-1:0];
                        state_d   = ST_IMM;
                    end
                end else begin
                    run     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT, ST_IMM: begin
                timer_d = timer_inc;
                // done takes priority over a timeout on the same cycle.
                if (done) begin
                    pc_d    = (state_q == ST_IMM) ? pc_inc2 : pc_inc1;
                    state_d = (pc_d >= len_q) ? ST_HALT : ST_FETCH;
                end else if (timer_inc == TIMEOUT_TC) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                 (state_q == ST_WAIT)  || (state_q == ST_IMM);
        halted = (state_q == ST_HALT);
        error  = (state_q == ST_ERR);
        case (state_q)
            ST_ISSUE, ST_WAIT, ST_IMM: din = instr;
            default:                   din = '0;
        endcase
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Testbench for instr_issuer. A behavioural model walks the loaded program
// by the interface rules (opcode legality, MVI immediate, done latency vs.
// timeout) and predicts every run pulse, din value, final status and pc.
module tb_instr_issuer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 15;
    localparam int AW      = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [8:0]    load_data;
    logic          start;
    logic [AW:0]   prog_len;
    logic          done;
    logic          run;
    logic [8:0]    din;
    logic          busy;
    logic          halted;
    logic          error;
    logic [1:0]    err_code;
    logic [AW:0]   pc_o;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int run_cnt = 0;
    int poke_pc = -1;

    logic [8:0] prog_m  [DEPTH];
    int         lat_tbl [DEPTH];

    instr_issuer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .prog_len  (prog_len),
        .done      (done),
        .run       (run),
        .din       (din),
        .busy      (busy),
        .halted    (halted),
        .error     (error),
        .err_code  (err_code),
        .pc        (pc_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (run === 1'b1) run_cnt <= run_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        done    = 1'b0;
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic load_word(input int a, input logic [8:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        prog_m[a] = d;
        step();
    endtask

    // Start the loaded program and follow it cycle by cycle against the model.
    task automatic exec_check(input int len, input bit wr0, input logic [8:0] wd0);
        int         mpc, t, lat, base, runs, fin;
        bit         mvi;
        logic [8:0] w;
        logic [1:0] code;
        base = run_cnt; runs = 0; fin = 0; code = 2'd0; mpc = 0;
        prog_len = (AW+1)'(len);
        start    = 1'b1;
        if (wr0) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_data = wd0;
            prog_m[0] = wd0;
        end
        cyc = 0;
        step();
        t = 2;
        if (len == 0) begin
            fin = 1;
            t   = 1;
        end
        while (fin == 0) begin
            w   = prog_m[mpc];
            mvi = (w[8:6] == 3'd1);
            while (cyc < t) step();
            chk("issue_busy", 32'(busy), 32'd1);
            chk("issue_pc", 32'(pc_o), 32'(mpc));
            if (w[8:6] > 3'd3) begin
                chk("illegal_norun", 32'(run), 32'd0);
                fin = 2; code = 2'd3; t = t + 1;
            end else if (mvi && (mpc + 1 >= len)) begin
                chk("trunc_norun", 32'(run), 32'd0);
                fin = 2; code = 2'd2; t = t + 1;
            end else begin
                chk("issue_run", 32'(run), 32'd1);
                chk("issue_din", 32'(din), 32'(w));
                runs++;
                lat = lat_tbl[mpc];
                for (int k = 1; k <= TIMEOUT; k++) begin
                    step();
                    if (mvi) chk("imm_din", 32'(din), 32'(prog_m[mpc+1]));
                    else     chk("wait_din", 32'(din), 32'(w));
                    if (k == 1 && mpc == poke_pc) begin
                        load_en   = 1'b1;
                        load_addr = '0;
                        load_data = ~prog_m[0];
                        start     = 1'b1;
                        prog_len  = 5'd1;
                    end
                    if (k == lat) begin
                        done = 1'b1;
                        break;
                    end
                end
                if (lat > TIMEOUT) begin
                    fin = 2; code = 2'd1; t = t + TIMEOUT + 1;
                end else begin
                    mpc = mpc + (mvi ? 2 : 1);
                    if (mpc >= len) begin
                        fin = 1; t = t + lat + 1;
                    end else begin
                        t = t + lat + 2;
                    end
                end
            end
        end
        while (cyc < t) step();
        chk("end_halted", 32'(halted), 32'(fin == 1));
        chk("end_error", 32'(error), 32'(fin == 2));
        chk("end_code", 32'(err_code), 32'(code));
        chk("end_pc", 32'(pc_o), 32'(mpc));
        chk("end_busy", 32'(busy), 32'd0);
        chk("run_count", 32'(run_cnt - base), 32'(runs));
        step(); step(); step();
        chk("sticky_runs", 32'(run_cnt - base), 32'(runs));
        chk("sticky_status", 32'({halted, error}), 32'({fin == 1, fin == 2}));
    endtask

    initial begin
        int         len_r, opr, base;
        logic [2:0] op3;
        resetn    = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        prog_len  = '0;
        done      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            prog_m[i]  = '0;
            lat_tbl[i] = 1;
        end

        @(negedge clk);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        resetn = 1'b1;
        step();

        // MV R1,R2 with done one cycle after run
        load_word(0, 9'o012);
        lat_tbl[0] = 1;
        exec_check(1, 1'b0, 9'd0);

        // MVI R3 + immediate, then ADD
        load_word(0, 9'o130);
        load_word(1, 9'h05A);
        load_word(2, 9'o231);
        lat_tbl[0] = 2;
        lat_tbl[2] = 1;
        exec_check(3, 1'b0, 9'd0);

        // timeout, then done exactly on the expiry cycle
        load_word(0, 9'o012);
        lat_tbl[0] = TIMEOUT + 5;
        exec_check(1, 1'b0, 9'd0);
        lat_tbl[0] = TIMEOUT;
        exec_check(1, 1'b0, 9'd0);

        // truncated MVI and illegal opcode
        load_word(0, 9'o130);
        exec_check(1, 1'b0, 9'd0);
        load_word(0, 9'o700);
        exec_check(1, 1'b0, 9'd0);

        // write together with start: FETCH sees the new word
        lat_tbl[0] = 3;
        exec_check(1, 1'b1, 9'o321);

        // load and start while busy are ignored; readback on a later run
        load_word(0, 9'o012);
        load_word(1, 9'o231);
        lat_tbl[0] = 4;
        lat_tbl[1] = 2;
        poke_pc = 0;
        exec_check(2, 1'b0, 9'd0);
        poke_pc = -1;
        exec_check(2, 1'b0, 9'd0);

        // full-depth program
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, {3'(i % 4 == 1 ? 0 : i % 4), 6'(i)});
            lat_tbl[i] = 1 + (i % 3);
        end
        exec_check(DEPTH, 1'b0, 9'd0);

        // randomized programs and done latencies
        for (int it = 0; it < 25; it++) begin
            len_r = $urandom_range(0, DEPTH);
            for (int i = 0; i < len_r; i++) begin
                opr = $urandom_range(0, 11);
                op3 = (opr < 11) ? 3'(opr % 4) : 3'($urandom_range(4, 7));
                load_word(i, {op3, 6'($urandom)});
                lat_tbl[i] = ($urandom_range(0, 19) == 0) ? TIMEOUT + 1
                                                          : $urandom_range(1, TIMEOUT);
            end
            exec_check(len_r, 1'b0, 9'd0);
        end

        // reset during IMM, then an empty program
        load_word(0, 9'o130);
        load_word(1, 9'h05A);
        prog_len = 5'd2;
        start    = 1'b1;
        cyc      = 0;
        step();
        step();
        chk("rimm_run", 32'(run), 32'd1);
        step();
        chk("rimm_din", 32'(din), 32'h05A);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_run", 32'(run), 32'd0);
        chk("arst_din", 32'(din), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_status", 32'({halted, error, err_code}), 32'd0);
        chk("arst_pc", 32'(pc_o), 32'd0);
        @(negedge clk);
        resetn   = 1'b1;
        base     = run_cnt;
        prog_len = 5'd0;
        start    = 1'b1;
        step();
        chk("len0_halted", 32'(halted), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        step(); step(); step();
        chk("len0_runs", 32'(run_cnt - base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
